// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one server port among NUM_CLIENTS clients.
// Latches the winner's transaction, returns read data with a one-cycle ack and aborts stalled grants.
module bus_arbiter #(
  parameter int unsigned NUM_CLIENTS    = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_CLIENTS-1:0]               cl_rq,
  input  logic [NUM_CLIENTS-1:0]               cl_wr_ni,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0]    cl_address,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0]    cl_dataW,
  output logic [NUM_CLIENTS-1:0]               cl_ack,
  output logic [DATA_WIDTH-1:0]                cl_dataR,
  output logic                                 srv_rq,
  output logic                                 srv_wr_ni,
  output logic [ADDR_WIDTH-1:0]                srv_address,
  output logic [DATA_WIDTH-1:0]                srv_dataW,
  input  logic                                 srv_ack,
  input  logic [DATA_WIDTH-1:0]                srv_dataR,
  output logic [$clog2(NUM_CLIENTS)-1:0]       grant_id,
  output logic                                 busy,
  output logic                                 timeout_err
);

  localparam int unsigned IDW  = $clog2(NUM_CLIENTS);
  localparam int unsigned CNTW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [IDW-1:0]          ptr_q, ptr_d;
  logic [IDW-1:0]          gid_q, gid_d;
  logic [CNTW-1:0]         tcnt_q, tcnt_d;
  logic                    mask_q, mask_d;
  logic                    srv_rq_q, srv_rq_d;
  logic                    srv_wr_q, srv_wr_d;
  logic [ADDR_WIDTH-1:0]   srv_addr_q, srv_addr_d;
  logic [DATA_WIDTH-1:0]   srv_dw_q, srv_dw_d;
  logic [DATA_WIDTH-1:0]   dr_q, dr_d;
  logic [NUM_CLIENTS-1:0]  ack_q, ack_d;
  logic                    busy_q, busy_d;
  logic                    terr_q, terr_d;

  logic [NUM_CLIENTS-1:0]  elig;
  logic                    found;
  logic [IDW-1:0]          win;
  logic [IDW-1:0]          ptr_next;

  // Rotating priority search starting at ptr; the last served client sits out one IDLE cycle.
  always_comb begin
    elig  = cl_rq & ~(mask_q ? (NUM_CLIENTS'(1) << gid_q) : '0);
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      int unsigned idx;
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
      if (!found && elig[IDW'(idx)]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  assign ptr_next = (gid_q == IDW'(NUM_CLIENTS - 1)) ? '0 : gid_q + IDW'(1);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gid_d      = gid_q;
    tcnt_d     = tcnt_q;
    mask_d     = mask_q;
    srv_wr_d   = srv_wr_q;
    srv_addr_d = srv_addr_q;
    srv_dw_d   = srv_dw_q;
    dr_d       = dr_q;
    ack_d      = '0;
    terr_d     = 1'b0;

    case (state_q)
      IDLE: begin
        mask_d = 1'b0;
        if (found) begin
          gid_d      = win;
          srv_wr_d   = cl_wr_ni[win];
          srv_addr_d = cl_address[win*ADDR_WIDTH +: ADDR_WIDTH];
          srv_dw_d   = cl_dataW[win*DATA_WIDTH +: DATA_WIDTH];
          tcnt_d     = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (srv_ack) begin
          dr_d    = srv_dataR;
          tcnt_d  = '0;
          ack_d   = NUM_CLIENTS'(1) << gid_q;
          state_d = ACK;
        end else if (tcnt_q == CNTW'(TIMEOUT_CYCLES - 1)) begin
          tcnt_d  = '0;
          terr_d  = 1'b1;
          ptr_d   = ptr_next;
          mask_d  = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + CNTW'(1);
        end
      end
      ACK: begin
        ptr_d   = ptr_next;
        mask_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    srv_rq_d = (state_d == GRANT);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gid_q      <= '0;
      tcnt_q     <= '0;
      mask_q     <= 1'b0;
      srv_rq_q   <= 1'b0;
      srv_wr_q   <= 1'b0;
      srv_addr_q <= '0;
      srv_dw_q   <= '0;
      dr_q       <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gid_q      <= gid_d;
      tcnt_q     <= tcnt_d;
      mask_q     <= mask_d;
      srv_rq_q   <= srv_rq_d;
      srv_wr_q   <= srv_wr_d;
      srv_addr_q <= srv_addr_d;
      srv_dw_q   <= srv_dw_d;
      dr_q       <= dr_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      terr_q     <= terr_d;
    end
  end

  assign cl_ack      = ack_q;
  assign cl_dataR    = dr_q;
  assign srv_rq      = srv_rq_q;
  assign srv_wr_ni   = srv_wr_q;
  assign srv_address = srv_addr_q;
  assign srv_dataW   = srv_dw_q;
  assign grant_id    = gid_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Lockstep bench for bus_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int TO = 15;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      cl_rq, cl_wr_ni, cl_ack;
  logic [N*AW-1:0]   cl_address;
  logic [N*DW-1:0]   cl_dataW;
  logic [DW-1:0]     cl_dataR, srv_dataW, srv_dataR;
  logic              srv_rq, srv_wr_ni, srv_ack, busy, timeout_err;
  logic [AW-1:0]     srv_address;
  logic [1:0]        grant_id;

  bus_arbiter #(.NUM_CLIENTS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .cl_rq(cl_rq), .cl_wr_ni(cl_wr_ni),
    .cl_address(cl_address), .cl_dataW(cl_dataW), .cl_ack(cl_ack), .cl_dataR(cl_dataR),
    .srv_rq(srv_rq), .srv_wr_ni(srv_wr_ni), .srv_address(srv_address), .srv_dataW(srv_dataW),
    .srv_ack(srv_ack), .srv_dataR(srv_dataR), .grant_id(grant_id), .busy(busy),
    .timeout_err(timeout_err));

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  // stimulus for the next cycle
  logic [N-1:0]    d_rq = '0, d_wr = '0;
  logic [N*AW-1:0] d_addr = '0;
  logic [N*DW-1:0] d_dw = '0;
  logic [DW-1:0]   d_sdr = '0;
  int              lat_force = 0;

  // reference model: phase 0 = idle, 1 = server owned, 2 = acknowledging
  int              m_ph, m_ptr, m_gid, m_cyc, m_lat;
  bit              m_mask, m_terr;
  logic            m_wr;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_dw, m_dr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_ptr = 0; m_gid = 0; m_cyc = 0; m_lat = 0;
    m_mask = 0; m_terr = 0; m_wr = 0; m_addr = '0; m_dw = '0; m_dr = '0;
  endtask

  function automatic int pick_lat();
    int r;
    if (lat_force >= 0) return lat_force;
    r = int'($urandom_range(0, 9));
    if (r < 6) return r % 4;
    if (r < 8) return TO - 1;
    return 99;
  endfunction

  task automatic chk_all();
    logic [N-1:0] exp_ack;
    exp_ack = (m_ph == 2) ? (N'(1) << m_gid) : '0;
    chk("srv_rq", 32'(srv_rq), 32'(m_ph == 1));
    chk("busy", 32'(busy), 32'(m_ph != 0));
    chk("cl_ack", 32'(cl_ack), 32'(exp_ack));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    chk("srv_wr_ni", 32'(srv_wr_ni), 32'(m_wr));
    chk("srv_address", 32'(srv_address), 32'(m_addr));
    chk("srv_dataW", 32'(srv_dataW), 32'(m_dw));
    chk("cl_dataR", 32'(cl_dataR), 32'(m_dr));
  endtask

  // One clock: drive, advance the model across the edge, check on the falling edge.
  task automatic step();
    logic [N-1:0] elig;
    logic         sack;
    bit           won;
    cl_rq = d_rq; cl_wr_ni = d_wr; cl_address = d_addr; cl_dataW = d_dw; srv_dataR = d_sdr;
    sack = (m_ph == 1 && m_cyc == m_lat);
    srv_ack = sack;
    @(posedge clk);
    cyc++;
    m_terr = 0;
    case (m_ph)
      0: begin
        elig = d_rq;
        if (m_mask) elig[m_gid] = 1'b0;
        m_mask = 0;
        won = 0;
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (!won && elig[c]) begin
            won = 1; m_gid = c; m_wr = d_wr[c];
            m_addr = d_addr[c*AW +: AW]; m_dw = d_dw[c*DW +: DW];
            m_ph = 1; m_cyc = 0; m_lat = pick_lat();
          end
        end
      end
      1: begin
        m_cyc++;
        if (sack) begin
          m_dr = d_sdr; m_ph = 2;
        end else if (m_cyc == TO) begin
          m_ph = 0; m_terr = 1; m_ptr = (m_gid + 1) % N; m_mask = 1;
        end
      end
      default: begin
        m_ph = 0; m_ptr = (m_gid + 1) % N; m_mask = 1;
      end
    endcase
    @(negedge clk);
    chk_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    chk_all();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int ack_seen, rq_cnt, last_ack, k;
    int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
    reset_n = 1'b0; cl_rq = '0; cl_wr_ni = '0; cl_address = '0; cl_dataW = '0;
    srv_ack = 1'b0; srv_dataR = '0;
    do_reset();

    // client 2 reads address 5, server answers two cycles into the grant
    d_rq = 4'b0100; d_wr = 4'b0100; d_addr = 16'h0500; d_sdr = 8'hA5; lat_force = 2;
    step();
    chk("t1_gid", 32'(grant_id), 32'd2);
    chk("t1_addr", 32'(srv_address), 32'd5);
    d_rq = '0;
    step(); step(); step();
    chk("t1_ack", 32'(cl_ack), 32'b0100);
    chk("t1_dataR", 32'(cl_dataR), 32'hA5);
    step();

    // all clients requesting continuously with immediate server ack
    do_reset();
    d_rq = 4'b1111; lat_force = 0; k = 0; last_ack = 0;
    for (int s = 0; s < 18; s++) begin
      d_sdr = 8'($urandom());
      step();
      if (cl_ack != '0 && k < 6) begin
        chk("rr_order", 32'(grant_id), 32'(exp_seq[k]));
        if (k > 0) chk("rr_gap", 32'(cyc - last_ack), 32'd3);
        last_ack = cyc;
        k++;
      end
    end
    chk("rr_count", 32'(k), 32'd6);

    // client 1 alone holding rq: one ack per four cycles, never back-to-back
    d_rq = '0;
    repeat (4) step();
    d_rq = 4'b0010; ack_seen = 0; last_ack = 0;
    for (int s = 0; s < 12; s++) begin
      step();
      if (cl_ack == 4'b0010) begin
        if (ack_seen > 0) chk("solo_gap", 32'(cyc - last_ack), 32'd4);
        last_ack = cyc;
        ack_seen++;
      end
    end
    chk("solo_acks", 32'(ack_seen), 32'd3);

    // write from client 3 with stable latched fields while client data changes
    d_rq = '0;
    repeat (4) step();
    d_rq = 4'b1000; d_wr = 4'b0000; d_addr = 16'hC000; d_dw = 32'h3C00_0000; lat_force = 3;
    step();
    d_rq = '0;
    for (int s = 0; s < 3; s++) begin
      d_dw = $urandom(); d_addr = 16'($urandom()); d_wr = 4'b1111;
      chk("wr_op", 32'(srv_wr_ni), 32'd0);
      chk("wr_addr", 32'(srv_address), 32'hC);
      chk("wr_data", 32'(srv_dataW), 32'h3C);
      step();
    end
    step(); step();

    // server never answers client 0; client 2 is next in line
    d_rq = 4'b0101; d_wr = 4'b0101; lat_force = 99; rq_cnt = 0; ack_seen = 0;
    step();
    chk("to_gid", 32'(grant_id), 32'd0);
    rq_cnt += int'(srv_rq);
    repeat (14) begin
      step();
      rq_cnt += int'(srv_rq);
      if (cl_ack != '0) ack_seen++;
    end
    lat_force = 0;
    step();
    chk("to_rq_cycles", 32'(rq_cnt), 32'(TO));
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_noack", 32'(ack_seen + int'(cl_ack != '0)), 32'd0);
    step();
    chk("to_next", 32'(grant_id), 32'd2);
    d_rq = '0;
    repeat (4) step();

    // random traffic
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 3) == 0) d_rq = N'($urandom());
      d_wr = N'($urandom()); d_addr = 16'($urandom()); d_dw = $urandom(); d_sdr = 8'($urandom());
      lat_force = -1;
      step();
    end

    // asynchronous reset in the middle of a grant
    d_rq = 4'b1111; lat_force = 99;
    step(); step();
    chk("rst_pre_rq", 32'(srv_rq), 32'd1);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_rq", 32'(srv_rq), 32'd0);
    chk("rst_ack", 32'(cl_ack), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    lat_force = 0;
    step();
    chk("rst_prio", 32'(grant_id), 32'd0);
    step(); step(); step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
